// File: rtl/channel_rr_merge_pkg.sv
// Shared types and helpers for the round-robin channel merge.
// Holds the grant search function and width helpers used by the top and the tests.
package channel_rr_merge_pkg;

    // Upper bound on the channel count supported by rr_pick.
    localparam int MAX_M     = 32;
    localparam int N_DEF     = 8;
    localparam int M_DEF     = 4;
    localparam int DEPTH_DEF = 4;

    // Result of a round-robin search: whether any channel was valid and which.
    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } pick_t;

    function automatic int idx_w(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int IDXW = idx_w(M_DEF);
    localparam int CNTW = cnt_w(DEPTH_DEF);

    // First valid channel searching rr, rr+1, ... wrapping at m.
    // rr is always < m, so one conditional subtract replaces a modulo.
    function automatic pick_t rr_pick(input logic [MAX_M-1:0] valid,
                                      input logic [31:0]      rr,
                                      input int unsigned      m);
        pick_t       p;
        logic [31:0] i;
        p = '0;
        for (int unsigned k = 0; k < MAX_M; k++) begin
            if ((k < m) && !p.found) begin
                i = rr + k;
                if (i >= m) begin
                    i = i - m;
                end
                if (valid[i[4:0]]) begin
                    p.found = 1'b1;
                    p.idx   = i[4:0];
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/channel_rr_merge_if.sv
// Handshake bundle between M producers, the merge, and one consumer.
// master: producer/consumer side; slave: the merge itself.
interface channel_rr_merge_if #(
    parameter int N  = 8,
    parameter int M  = 4,
    parameter int OW = 8
);
    logic [M-1:0][N-1:0] in_d;
    logic [M-1:0]        in_v;
    logic [M-1:0]        in_a;
    logic [OW-1:0]       out_d;
    logic                out_v;
    logic                out_a;

    modport master (
        output in_d, in_v, out_a,
        input  in_a, out_d, out_v
    );

    modport slave (
        input  in_d, in_v, out_a,
        output in_a, out_d, out_v
    );
endinterface

// File: rtl/channel_rr_merge_fifo.sv
// Small synchronous FIFO: push/pop/count/head, no handshake logic of its own.
// Head is read combinationally from the read pointer; the non-empty flag is registered.
module channel_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [W-1:0]               i_din,
    output logic [W-1:0]               o_head,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_nempty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_count;
    logic          r_nempty;
    logic [CW-1:0] w_count_nxt;

    // Next occupancy from the push/pop pair.
    always_comb begin
        w_count_nxt = r_count;
        case ({i_push, i_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage write; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr] <= i_din;
        end
    end

    // Pointers, occupancy and registered non-empty flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr     <= '0;
            r_rd     <= '0;
            r_count  <= '0;
            r_nempty <= 1'b0;
        end else begin
            if (i_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (i_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            r_count  <= w_count_nxt;
            r_nempty <= (w_count_nxt != '0);
        end
    end

    assign o_head   = r_mem[r_rd];
    assign o_count  = r_count;
    assign o_nempty = r_nempty;
endmodule

// File: rtl/channel_rr_merge.sv
// M-input round-robin merge into one FIFO-buffered output channel.
// in_a depends only on in_v and registered state (never on out_a), and a full
// FIFO blocks every input even in a cycle where the consumer pops.
// Build option CHANNEL_MERGE_TAG_EN: when defined, each entry also stores the
// granted channel index and out_d = {index, data}; otherwise out_d = data.
module channel_rr_merge
    import channel_rr_merge_pkg::*;
#(
    parameter int N     = 8,
    parameter int M     = 4,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    channel_rr_merge_if.slave bus
);
    localparam int IW = idx_w(M);
    localparam int CW = cnt_w(DEPTH);
`ifdef CHANNEL_MERGE_TAG_EN
    localparam int OW = N + IW;
`else
    localparam int OW = N;
`endif

    logic [IW-1:0]    r_rr;
    logic [MAX_M-1:0] w_valid_ext;
    pick_t            w_pick;
    logic [IW-1:0]    w_gidx;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [OW-1:0]    w_push_d;
    logic [OW-1:0]    w_head;
    logic [CW-1:0]    w_count;
    logic             w_nempty;

    // Widen the valid vector to the search function's fixed width.
    always_comb begin
        w_valid_ext        = '0;
        w_valid_ext[M-1:0] = bus.in_v;
    end

    assign w_pick = rr_pick(w_valid_ext, 32'(r_rr), M);
    assign w_gidx = w_pick.idx[IW-1:0];
    assign w_full = (w_count == CW'(DEPTH));
    // Reset forces every acknowledge low regardless of in_v.
    assign w_push = !reset && !w_full && w_pick.found;
    assign w_pop  = w_nempty && bus.out_a;

    // One-hot acknowledge to the granted channel.
    always_comb begin
        bus.in_a = '0;
        if (w_push) begin
            bus.in_a[w_gidx] = 1'b1;
        end
    end

`ifdef CHANNEL_MERGE_TAG_EN
    assign w_push_d = {w_gidx, bus.in_d[w_gidx]};
`else
    assign w_push_d = bus.in_d[w_gidx];
`endif

    // Round-robin pointer moves past the winner; holds when nothing is granted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr <= '0;
        end else if (w_push) begin
            r_rr <= (w_gidx == IW'(M - 1)) ? '0 : w_gidx + 1'b1;
        end
    end

    channel_fifo #(
        .W     (OW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .i_push   (w_push),
        .i_pop    (w_pop),
        .i_din    (w_push_d),
        .o_head   (w_head),
        .o_count  (w_count),
        .o_nempty (w_nempty)
    );

    assign bus.out_v = w_nempty;
    assign bus.out_d = w_head;
endmodule

// File: tb/tb_channel_rr_merge.sv
// Bench for channel_rr_merge (N=8, M=4, DEPTH=4): directed grant/latency/backpressure/reset
// cases plus a random producer/consumer run, with a scoreboard of expected output words.
// Works with and without CHANNEL_MERGE_TAG_EN.
module tb_channel_rr_merge;
`ifdef CHANNEL_MERGE_TAG_EN
    localparam int OW = 10;
`else
    localparam int OW = 8;
`endif
    localparam int WPC   = 1000;
    localparam int TOTAL = 4 * WPC;
    localparam int LIMIT = 90000;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   rcvd  = 0;
    bit   rnd_mode = 1'b0;

    logic [OW-1:0] sb_q[$];
    logic [OW-1:0] exp_q[4][$];

    channel_rr_merge_if #(.N(8), .M(4), .OW(OW)) bus ();

    channel_rr_merge #(.N(8), .M(4), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [OW-1:0] exp_out(input int ch, input logic [7:0] d);
        logic [1:0] t;
        t = ch[1:0];
        return OW'({t, d});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: compare each transfer against the scoreboard, record new acceptances.
    always @(negedge clk) begin
        if (!reset) begin
            if (!rnd_mode) begin
                if (bus.out_v && bus.out_a) begin
                    chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                    if (sb_q.size() != 0) chk("sb_data", 32'(bus.out_d), 32'(sb_q.pop_front()));
                end
                for (int i = 0; i < 4; i++) begin
                    if (bus.in_a[i]) sb_q.push_back(exp_out(i, bus.in_d[i]));
                end
            end else if (bus.out_v && bus.out_a) begin
                int ch;
                ch = int'(bus.out_d[7:6]);
                chk("rand_nonempty", 32'(exp_q[ch].size() != 0), 32'd1);
                if (exp_q[ch].size() != 0) chk("rand_data", 32'(bus.out_d), 32'(exp_q[ch].pop_front()));
                rcvd++;
            end
        end
    end

    task automatic producer(input int c);
        logic [7:0] d;
        for (int s = 0; s < WPC; s++) begin
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
            d = {c[1:0], s[5:0]};
            bus.in_d[c] = d;
            bus.in_v[c] = 1'b1;
            exp_q[c].push_back(exp_out(c, d));
            do @(negedge clk); while (!bus.in_a[c] && cyc < LIMIT);
            @(posedge clk);
            #1;
            bus.in_v[c] = 1'b0;
            if (cyc >= LIMIT) break;
        end
    endtask

    task automatic sink();
        while (rcvd < TOTAL && cyc < LIMIT) begin
            bus.out_a = 1'b0;
            repeat ($urandom_range(0, 5)) step();
            bus.out_a = 1'b1;
            do @(negedge clk); while (!bus.out_v && cyc < LIMIT);
            step();
        end
    endtask

    initial begin
        bus.in_v  = 4'hF;
        bus.in_d  = '0;
        bus.out_a = 1'b1;

        // Reset holds acknowledges low even with every input valid.
        repeat (2) @(negedge clk);
        chk("rst_in_a", 32'(bus.in_a), 32'h0);
        chk("rst_out_v", 32'(bus.out_v), 32'h0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        bus.in_v = 4'h0;
        step();

        // 1: single producer on channel 2.
        bus.in_v    = 4'b0100;
        bus.in_d[2] = 8'hA5;
        @(negedge clk);
        chk("t1_ack", 32'(bus.in_a), 32'b0100);
        step();
        bus.in_v = 4'h0;
        @(negedge clk);
        chk("t1_out_v", 32'(bus.out_v), 32'h1);
        chk("t1_out_d", 32'(bus.out_d), 32'(exp_out(2, 8'hA5)));
        step();
        @(negedge clk);
        chk("t1_empty", 32'(bus.out_v), 32'h0);
        step();

        // 4: rr=3 with 0011 -> 0 then 1; steer rr to 1, then 1001 -> 3.
        bus.in_v    = 4'b0011;
        bus.in_d[0] = 8'h10;
        bus.in_d[1] = 8'h11;
        @(negedge clk);
        chk("t4_grant0", 32'(bus.in_a), 32'b0001);
        step();
        bus.in_v = 4'b0010;
        @(negedge clk);
        chk("t4_grant1", 32'(bus.in_a), 32'b0010);
        step();
        bus.in_v    = 4'b0001;
        bus.in_d[0] = 8'h12;
        step();
        bus.in_v    = 4'b1001;
        bus.in_d[3] = 8'h13;
        @(negedge clk);
        chk("t4_grant3", 32'(bus.in_a), 32'b1000);
        step();
        bus.in_v = 4'h0;
        repeat (6) step();

        // 2: all valid, d[i]=i: grants rotate, one word per cycle.
        for (int i = 0; i < 4; i++) bus.in_d[i] = 8'(i);
        bus.in_v = 4'hF;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("t2_grant", 32'(bus.in_a), 32'(1 << (k % 4)));
            if (k > 0) begin
                chk("t2_out_v", 32'(bus.out_v), 32'h1);
                chk("t2_out_d", 32'(bus.out_d), 32'(exp_out((k - 1) % 4, 8'((k - 1) % 4))));
            end
            step();
        end
        bus.in_v = 4'h0;
        repeat (6) step();

        // 3: backpressure fills the FIFO, then pops resume acceptance.
        begin
            int acc;
            acc = 0;
            bus.out_a = 1'b0;
            for (int i = 0; i < 4; i++) bus.in_d[i] = 8'(8'h20 + i);
            bus.in_v = 4'hF;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                if (bus.in_a != 4'h0) acc++;
                step();
            end
            chk("t3_accepted", 32'(acc), 32'd4);
            @(negedge clk);
            chk("t3_full", 32'(bus.in_a), 32'h0);
            step();
            bus.out_a = 1'b1;
            @(negedge clk);
            chk("t3_full_pop", 32'(bus.in_a), 32'h0);
            chk("t3_out_v", 32'(bus.out_v), 32'h1);
            step();
            @(negedge clk);
            chk("t3_resume", 32'(bus.in_a != 4'h0), 32'h1);
            step();
            bus.in_v = 4'h0;
            repeat (8) step();
        end

        // 5: async reset with three words queued.
        bus.out_a   = 1'b0;
        bus.in_v    = 4'b0001;
        bus.in_d[0] = 8'h30;
        repeat (3) step();
        #2;
        reset = 1'b1;
        sb_q.delete();
        #1;
        chk("t5_out_v", 32'(bus.out_v), 32'h0);
        chk("t5_in_a", 32'(bus.in_a), 32'h0);
        @(posedge clk);
        #1;
        reset       = 1'b0;
        bus.in_v    = 4'b1010;
        bus.in_d[1] = 8'h31;
        bus.in_d[3] = 8'h33;
        @(negedge clk);
        chk("t5_out_v_rel", 32'(bus.out_v), 32'h0);
        chk("t5_first", 32'(bus.in_a), 32'b0010);
        step();
        bus.in_v = 4'b1000;
        @(negedge clk);
        chk("t5_second", 32'(bus.in_a), 32'b1000);
        step();
        bus.in_v  = 4'h0;
        bus.out_a = 1'b1;
        repeat (6) step();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        // 6: random producers and consumer.
        rnd_mode = 1'b1;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    fork
                        automatic int c = i;
                        producer(c);
                    join_none
                end
                wait fork;
            end
            sink();
        join
        chk("rand_count", 32'(rcvd), 32'(TOTAL));
        for (int i = 0; i < 4; i++) chk("rand_left", 32'(exp_q[i].size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
